// File: rtl/pe_arr_pkg.sv
// Shared widths, types and the product helper for the systolic MAC array.
// Optional feature macro: PE_ARR_SIGNED_EN selects two's-complement operands.
package pe_arr_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0]  acc_t;

  // Full-precision product widened to the accumulator width.
  function automatic acc_t mul_ext(input data_t a, input data_t b);
`ifdef PE_ARR_SIGNED_EN
    logic signed [PROD_W-1:0] p;
    p = $signed(a) * $signed(b);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
`else
    logic [PROD_W-1:0] p;
    p = a * b;
    return {{(ACC_W-PROD_W){1'b0}}, p};
`endif
  endfunction

endpackage

// File: rtl/pe_arr_cell.sv
// One output-stationary processing element: registers the streaming operands
// and valid, and accumulates a dot product over each contiguous valid run.
module pe_cell
  import pe_arr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  data_t a_in,
  input  data_t w_in,
  input  logic  v_in,
  output data_t a_out,
  output data_t w_out,
  output logic  v_out,
  output acc_t  acc,
  output logic  done
);

  data_t a_q, a_d;
  data_t w_q, w_d;
  logic  v_q, v_d;
  logic  vp_q, vp_d;
  acc_t  acc_q, acc_d;
  logic  done_q, done_d;

  logic  first_valid;
  acc_t  prod;

  // vp_q remembers the previous v_q so a run start can be told apart.
  always_comb begin
    a_d         = a_in;
    w_d         = w_in;
    v_d         = v_in;
    vp_d        = v_q;
    first_valid = v_q & ~vp_q;
    prod        = mul_ext(a_q, w_q);
    acc_d       = acc_q;
    if (v_q) begin
      if (first_valid) begin
        acc_d = prod;
      end else begin
        acc_d = acc_q + prod;
      end
    end
    done_d = v_q & ~v_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      w_q    <= '0;
      v_q    <= 1'b0;
      vp_q   <= 1'b0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      w_q    <= w_d;
      v_q    <= v_d;
      vp_q   <= vp_d;
      acc_q  <= acc_d;
      done_q <= done_d;
    end
  end

  assign a_out = a_q;
  assign w_out = w_q;
  assign v_out = v_q;
  assign acc   = acc_q;
  assign done  = done_q;

endmodule

// File: rtl/pe_arr.sv
// ROWS x COLS output-stationary systolic MAC array built from pe_cell.
// Optional feature macro: PE_ARR_SIGNED_EN (signed operands, see pe_arr_pkg).
module pe_arr
  import pe_arr_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire,
  input  logic [DATA_W-1:0] in_w      [0:COLS-1],
  input  logic [DATA_W-1:0] in_a      [0:ROWS-1],
  output logic [ACC_W-1:0]  outs      [0:ROWS*COLS-1],
  output logic              outvalids [0:ROWS*COLS-1]
);

  // fire is a valid-only qualifier: there is no ready, the array never stalls,
  // and in_a/in_w are consumed in every cycle fire is high. The caller skews
  // in_a[r] by r cycles and in_w[c] by c cycles relative to fire.

  data_t a_pipe [0:ROWS-1][0:COLS-1];
  data_t w_pipe [0:ROWS-1][0:COLS-1];
  logic  v_pipe [0:ROWS-1][0:COLS-1];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      data_t a_src;
      data_t w_src;
      logic  v_src;

      if (c == 0) begin : g_a_edge
        assign a_src = in_a[r];
      end else begin : g_a_chain
        assign a_src = a_pipe[r][c-1];
      end

      if (r == 0) begin : g_w_edge
        assign w_src = in_w[c];
      end else begin : g_w_chain
        assign w_src = w_pipe[r-1][c];
      end

      // Valid runs along row 0's left column, then across each row.
      if (r == 0 && c == 0) begin : g_v_root
        assign v_src = fire;
      end else if (c > 0) begin : g_v_row
        assign v_src = v_pipe[r][c-1];
      end else begin : g_v_col
        assign v_src = v_pipe[r-1][0];
      end

      pe_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .a_in  (a_src),
        .w_in  (w_src),
        .v_in  (v_src),
        .a_out (a_pipe[r][c]),
        .w_out (w_pipe[r][c]),
        .v_out (v_pipe[r][c]),
        .acc   (outs[r*COLS+c]),
        .done  (outvalids[r*COLS+c])
      );
    end
  end

endmodule

// File: tb/tb_pe_arr.sv
// Directed and randomized bench for pe_arr with a timed result scoreboard.
module tb_pe_arr;
  import pe_arr_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int NPE  = ROWS * COLS;
  localparam int MAXT = 32;
`ifdef PE_ARR_SIGNED_EN
  localparam logic [31:0] SIGN_EXP = 32'hFFFF_FFF4;
`else
  localparam logic [31:0] SIGN_EXP = 32'd1524;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fire;
  logic [7:0]  in_w      [0:COLS-1];
  logic [7:0]  in_a      [0:ROWS-1];
  logic [31:0] outs      [0:NPE-1];
  logic        outvalids [0:NPE-1];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entry: {cycle, pe index, accumulator value}.
  logic [55:0] exp_q[$];
  logic [31:0] last_val [0:NPE-1];

  logic        fire_tl [0:MAXT-1];
  logic [7:0]  a_tl    [0:ROWS-1][0:MAXT-1];
  logic [7:0]  w_tl    [0:COLS-1][0:MAXT-1];
  int          tl_len;

  pe_arr #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .fire      (fire),
    .in_w      (in_w),
    .in_a      (in_a),
    .outs      (outs),
    .outvalids (outvalids)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  function automatic logic [31:0] prod(input logic [7:0] a, input logic [7:0] w);
`ifdef PE_ARR_SIGNED_EN
    return 32'(int'($signed(a)) * int'($signed(w)));
`else
    return 32'(a) * 32'(w);
`endif
  endfunction

  // ---------------- checkers ----------------
  task automatic check_pulses();
    logic [55:0] got;
    logic [55:0] exp;
    for (int i = 0; i < NPE; i++) begin
      if (outvalids[i] !== 1'b0) begin
        got = {cyc[15:0], 8'(i), outs[i]};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {16'hFFFF, 8'hFF, 32'h0};
        n_tests++;
        assert (got === exp) else begin
          n_fail++;
          $error("FAIL pulse observed={cyc,pe,acc}=%0h expected=%0h", got, exp);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc_or;
    logic        v_or;
    acc_or = '0;
    v_or   = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      acc_or = acc_or | outs[i];
      v_or   = v_or | outvalids[i];
    end
    n_tests++;
    assert ({v_or, acc_or} === 33'b0) else begin
      n_fail++;
      $error("FAIL %s observed valid_or=%0b outs_or=%0h expected 0/0", tag, v_or, acc_or);
    end
  endtask

  task automatic check_hold(input string tag);
    for (int i = 0; i < NPE; i++) begin
      n_tests++;
      assert (outs[i] === last_val[i]) else begin
        n_fail++;
        $error("FAIL %s pe=%0d observed=%0h expected=%0h", tag, i, outs[i], last_val[i]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_pulses();
  endtask

  task automatic clear_inputs();
    fire = 1'b0;
    for (int r = 0; r < ROWS; r++) in_a[r] = '0;
    for (int c = 0; c < COLS; c++) in_w[c] = '0;
  endtask

  // Drives the stored timeline (skewed or held constant) and pushes every
  // expected done pulse, in time then index order, before the first step.
  task automatic run_timeline(input bit skew, input string tag);
    int          c0;
    int          total;
    int          t;
    int          k;
    logic [31:0] sum;
    step();
    c0    = cyc;
    total = tl_len + ROWS + COLS + 2;
    for (int e = 0; e <= total; e++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          for (int te = 0; te < tl_len; te++) begin
            if (fire_tl[te] && (te == tl_len - 1 || !fire_tl[te+1]) && (te + r + c + 2 == e)) begin
              sum = '0;
              t   = te;
              while (t >= 0 && fire_tl[t]) begin
                sum = sum + prod(a_tl[r][t], w_tl[c][t]);
                t--;
              end
              exp_q.push_back({16'(c0 + e), 8'(r * COLS + c), sum});
              last_val[r*COLS+c] = sum;
            end
          end
        end
      end
    end
    for (int s = 0; s < total; s++) begin
      if (s > 0) step();
      fire = (s < tl_len) ? fire_tl[s] : 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        k = s - r;
        if (!skew) in_a[r] = a_tl[r][0];
        else       in_a[r] = (k >= 0 && k < tl_len) ? a_tl[r][k] : 8'h00;
      end
      for (int c = 0; c < COLS; c++) begin
        k = s - c;
        if (!skew) in_w[c] = w_tl[c][0];
        else       in_w[c] = (k >= 0 && k < tl_len) ? w_tl[c][k] : 8'h00;
      end
    end
    step();
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_missing observed=%0d pending expected=0", tag, exp_q.size());
    end
    exp_q.delete();
    check_hold({tag, "_hold"});
  endtask

  task automatic set_const(input int len, input logic [7:0] a, input logic [7:0] w);
    tl_len = len;
    for (int t = 0; t < MAXT; t++) begin
      fire_tl[t] = (t < len);
      for (int r = 0; r < ROWS; r++) a_tl[r][t] = a;
      for (int c = 0; c < COLS; c++) w_tl[c][t] = w;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < NPE; i++) last_val[i] = '0;
    repeat (2) step();
    check_all_zero("in_reset");
    rst = 1'b0;
    repeat (20) begin
      step();
      check_all_zero("idle");
    end

    // Constant operands, inputs held (no skew needed).
    set_const(4, 8'd3, 8'd1);
    run_timeline(1'b0, "const");

    // Skewed dot product: rows stream 1..4, columns stream 2.
    set_const(4, 8'd0, 8'd2);
    for (int r = 0; r < ROWS; r++)
      for (int t = 0; t < 4; t++) a_tl[r][t] = 8'(t + 1);
    run_timeline(1'b1, "skew_dot");

    // Back-to-back runs separated by one idle cycle.
    set_const(6, 8'd1, 8'd1);
    fire_tl[3] = 1'b0;
    for (int t = 4; t < 6; t++) begin
      for (int r = 0; r < ROWS; r++) a_tl[r][t] = 8'd5;
      for (int c = 0; c < COLS; c++) w_tl[c][t] = 8'd2;
    end
    run_timeline(1'b1, "b2b");

    // Random operands, skewed.
    set_const(6, 8'd0, 8'd0);
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < ROWS; r++) a_tl[r][t] = 8'($urandom_range(0, 255));
      for (int c = 0; c < COLS; c++) w_tl[c][t] = 8'($urandom_range(0, 255));
    end
    run_timeline(1'b1, "random");

    // Signedness of 8'hFE * 3 over two cycles.
    set_const(2, 8'hFE, 8'd3);
    run_timeline(1'b0, "sign");
    n_tests++;
    assert (outs[NPE-1] === SIGN_EXP) else begin
      n_fail++;
      $error("FAIL sign_value observed=%0h expected=%0h", outs[NPE-1], SIGN_EXP);
    end

    // Reset while PE(3,3) is accumulating: fire 8 cycles, stop after 8 edges.
    clear_inputs();
    for (int s = 0; s < 8; s++) begin
      step();
      fire = 1'b1;
      for (int r = 0; r < ROWS; r++) in_a[r] = 8'd1;
      for (int c = 0; c < COLS; c++) in_w[c] = 8'd1;
    end
    step();
    n_tests++;
    assert ({outs[3*COLS+3], outs[0]} === {32'd1, 32'd7}) else begin
      n_fail++;
      $error("FAIL midrun_acc observed pe33=%0d pe00=%0d expected 1/7", outs[3*COLS+3], outs[0]);
    end
    rst = 1'b1;
    #1;
    check_all_zero("reset_abort");
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
    repeat (20) begin
      step();
      check_all_zero("after_abort");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
